// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction fetch stage with PC register, branch target
// generation and the IF/ID pipeline register.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-low reset
//   stall          in   hold PC and IF/ID
//   flush          in   bubble the next IF/ID contents
//   br_taken       in   redirect fetch this cycle (wins over stall)
//   br_sel   [1:0] in   00 imm19, 01 imm26, 10 register, 11 as 00
//   br_pc   [63:0] in   PC of the branch (from ID)
//   imm19   [18:0] in   signed word offset (CBZ, B.cond)
//   imm26   [25:0] in   signed word offset (B, BL)
//   br_reg_target  in   register target for BR
//   imem_addr      out  instruction address (= PC register)
//   imem_data      in   instruction word at imem_addr, same cycle
//   if_id_instr    out  registered instruction
//   if_id_pc       out  registered PC of if_id_instr
//   if_id_pc_plus4 out  registered PC+4 (BL link value)
//   if_id_valid    out  IF/ID holds a real instruction
module ifetch_stage #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        br_taken,
   input  logic [1:0]  br_sel,
   input  logic [63:0] br_pc,
   input  logic [18:0] imm19,
   input  logic [25:0] imm26,
   input  logic [63:0] br_reg_target,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] if_id_instr,
   output logic [63:0] if_id_pc,
   output logic [63:0] if_id_pc_plus4,
   output logic        if_id_valid
);

   logic [63:0] r_pc;
   logic [31:0] r_instr;
   logic [63:0] r_ipc;
   logic [63:0] r_ipc4;
   logic        r_valid;

   logic [63:0] w_target;
   logic [63:0] w_pc_plus4;

   assign w_pc_plus4 = r_pc + 64'd4;

   // Offsets are word offsets: sign-extend then shift by two.
   // Register targets drop their low bits so the PC stays word aligned.
   always_comb begin
      w_target = br_pc + {{43{imm19[18]}}, imm19, 2'b00};
      case (br_sel)
         2'b01:   w_target = br_pc + {{36{imm26[25]}}, imm26, 2'b00};
         2'b10:   w_target = {br_reg_target[63:2], 2'b00};
         default: w_target = br_pc + {{43{imm19[18]}}, imm19, 2'b00};
      endcase
   end

   // PC: redirect beats stall so a branch resolved under a stall is kept.
   always_ff @(posedge clk) begin
      if (!reset)
         r_pc <= {RESET_PC[63:2], 2'b00};
      else if (br_taken)
         r_pc <= w_target;
      else if (!stall)
         r_pc <= w_pc_plus4;
   end

   // IF/ID: the word fetched in a redirect cycle is the wrong path, so it
   // is replaced by a bubble rather than held.
   always_ff @(posedge clk) begin
      if (!reset || br_taken || flush) begin
         r_instr <= NOP_INSTR;
         r_ipc   <= 64'd0;
         r_ipc4  <= 64'd0;
         r_valid <= 1'b0;
      end else if (!stall) begin
         r_instr <= imem_data;
         r_ipc   <= r_pc;
         r_ipc4  <= w_pc_plus4;
         r_valid <= 1'b1;
      end
   end

   assign imem_addr      = r_pc;
   assign if_id_instr    = r_instr;
   assign if_id_pc       = r_ipc;
   assign if_id_pc_plus4 = r_ipc4;
   assign if_id_valid    = r_valid;

endmodule
